// File: rtl/memsplit_dma_master_if.sv
// MemSplit32 request/acknowledge/response bus bundle.
// The DMA engine drives it through the master modport, and a memory or CSR
// responder answers through the slave modport.
interface memsplit_dma_master_if;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_bo;
  logic [3:0]  bus_be_bo;
  logic [31:0] bus_wdata_bo;
  logic        bus_ack_i;
  logic        bus_resp_i;
  logic [31:0] bus_rdata_bi;

  modport master (
    output bus_req_o, bus_we_o, bus_addr_bo, bus_be_bo, bus_wdata_bo,
    input  bus_ack_i, bus_resp_i, bus_rdata_bi
  );

  modport slave (
    input  bus_req_o, bus_we_o, bus_addr_bo, bus_be_bo, bus_wdata_bo,
    output bus_ack_i, bus_resp_i, bus_rdata_bi
  );
endinterface

// File: rtl/memsplit_dma_master.sv
// MemSplit32 block-copy DMA master.
// For each word the engine issues one read, waits for the read response, and
// then writes the captured data. A watchdog aborts any bus phase that stalls
// for BUS_TIMEOUT cycles.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  IDLE    | no transfer; start_i is sampled here
//  RD_REQ  | read request on the bus, waiting for ack
//  RD_WAIT | read accepted, waiting for resp and its data
//  WR_REQ  | write request with the captured data, waiting for ack
module memsplit_dma_master #(
  parameter int BUS_TIMEOUT = 1024,
  parameter int LEN_W       = 16
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [31:0]           src_addr_bi,
  input  logic [31:0]           dst_addr_bi,
  input  logic [LEN_W-1:0]      len_bi,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [LEN_W-1:0]      words_done_bo,
  memsplit_dma_master_if.master bus
);

  localparam int          CNT_W     = $clog2(BUS_TIMEOUT + 1);
  localparam logic [31:0] ADDR_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ} state_t;

  state_t           state_q, state_d;
  logic [31:0]      src_q, src_d, dst_q, dst_d;
  logic [31:0]      addr_q, addr_d, wdata_q, wdata_d;
  logic [LEN_W-1:0] len_q, len_d, words_q, words_d, words_inc;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]       be_q, be_d;
  logic             req_q, req_d, we_q, we_d;
  logic             done_q, done_d, err_q, err_d;
  logic             ack_ok, tmo;

  // An ack counts only while a request is actually on the bus.
  assign ack_ok    = bus.bus_ack_i && req_q;
  assign cnt_inc   = cnt_q + CNT_W'(1);
  // The phase times out when one more idle cycle would bring the counter to BUS_TIMEOUT.
  assign tmo       = (cnt_inc == CNT_W'(BUS_TIMEOUT));
  assign words_inc = words_q + LEN_W'(1);

  // Decode the next state and next values for every registered output.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    words_d = words_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    req_d   = req_q;
    we_d    = we_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    cnt_d   = cnt_inc;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start_i) begin
          words_d = '0;
          if (len_bi != '0) begin
            src_d   = src_addr_bi & ADDR_MASK;
            dst_d   = dst_addr_bi & ADDR_MASK;
            len_d   = len_bi;
            addr_d  = src_addr_bi & ADDR_MASK;
            req_d   = 1'b1;
            we_d    = 1'b0;
            be_d    = 4'hF;
            state_d = RD_REQ;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RD_REQ: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (ack_ok) begin
          req_d   = 1'b0;
          state_d = RD_WAIT;
        end else if (tmo) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      RD_WAIT: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (bus.bus_resp_i) begin
          wdata_d = bus.bus_rdata_bi;
          addr_d  = dst_q;
          req_d   = 1'b1;
          we_d    = 1'b1;
          state_d = WR_REQ;
        end else if (tmo) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      WR_REQ: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (ack_ok) begin
          words_d = words_inc;
          src_d   = src_q + 32'd4;
          dst_d   = dst_q + 32'd4;
          if (words_inc == len_q) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            addr_d  = src_q + 32'd4;
            we_d    = 1'b0;
            state_d = RD_REQ;
          end
        end else if (tmo) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Leaving a bus phase for IDLE always releases the bus.
    if (state_d == IDLE && state_q != IDLE) begin
      req_d = 1'b0;
      we_d  = 1'b0;
    end
    if (state_d != state_q) begin
      cnt_d = '0;
    end
  end

  // State and output registers. An asynchronous reset drops the bus request at once.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      words_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      words_q <= words_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      req_q   <= req_d;
      we_q    <= we_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy_o           = (state_q != IDLE);
  assign done_o           = done_q;
  assign err_o            = err_q;
  assign words_done_bo    = words_q;
  assign bus.bus_req_o    = req_q;
  assign bus.bus_we_o     = we_q;
  assign bus.bus_addr_bo  = addr_q;
  assign bus.bus_be_bo    = be_q;
  assign bus.bus_wdata_bo = wdata_q;

endmodule

// File: tb/tb_memsplit_dma_master.sv
// Bench for memsplit_dma_master. A responder drives ack in the same cycle as req,
// returns resp one full cycle after the ack cycle, and logs every accepted transaction.
`timescale 1ns/1ps
module tb_memsplit_dma_master;

  localparam int TMO = 8;

  logic        clk_i;
  logic        arst_i;
  logic        start_i;
  logic        abort_i;
  logic [31:0] src_addr_bi;
  logic [31:0] dst_addr_bi;
  logic [15:0] len_bi;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic [15:0] words_done_bo;

  memsplit_dma_master_if ifc();

  memsplit_dma_master #(.BUS_TIMEOUT(TMO), .LEN_W(16)) dut (
    .clk_i         (clk_i),
    .arst_i        (arst_i),
    .start_i       (start_i),
    .abort_i       (abort_i),
    .src_addr_bi   (src_addr_bi),
    .dst_addr_bi   (dst_addr_bi),
    .len_bi        (len_bi),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .err_o         (err_o),
    .words_done_bo (words_done_bo),
    .bus           (ifc)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mdl(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h3C00_00C3;
  endfunction

  // responder state
  logic [31:0] rd_log[$];
  logic [31:0] wr_addr_log[$];
  logic [31:0] wr_data_log[$];
  int          rd_acc     = 0;
  int          stall_idx  = 0;
  int          stall_left = 0;
  logic [31:0] stall_addr = '0;
  bit          resp_on    = 1'b1;
  int          resp_pend  = 0;
  logic [31:0] resp_addr  = '0;

  task automatic clear_logs();
    rd_log.delete();
    wr_addr_log.delete();
    wr_data_log.delete();
    rd_acc = 0;
  endtask

  // Memory responder: decides ack/resp for each cycle at the falling edge.
  initial begin
    ifc.bus_ack_i    = 1'b0;
    ifc.bus_resp_i   = 1'b0;
    ifc.bus_rdata_bi = '0;
    forever begin
      @(negedge clk_i);
      ifc.bus_resp_i = 1'b0;
      if (resp_pend > 0) begin
        resp_pend--;
        if (resp_pend == 0 && resp_on) begin
          ifc.bus_resp_i   = 1'b1;
          ifc.bus_rdata_bi = mdl(resp_addr);
        end
      end
      ifc.bus_ack_i = 1'b0;
      if (ifc.bus_req_o) begin
        if (!ifc.bus_we_o && rd_acc == stall_idx && stall_left > 0) begin
          stall_left--;
          check("stall_addr_hold", ifc.bus_addr_bo, stall_addr);
        end else begin
          ifc.bus_ack_i = 1'b1;
          if (ifc.bus_we_o) begin
            wr_addr_log.push_back(ifc.bus_addr_bo);
            wr_data_log.push_back(ifc.bus_wdata_bo);
          end else begin
            rd_log.push_back(ifc.bus_addr_bo);
            resp_addr = ifc.bus_addr_bo;
            resp_pend = 2;
            rd_acc++;
          end
        end
      end
    end
  end

  typedef struct packed {
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] len;
    logic [31:0] stall_idx;
    logic [31:0] stall_n;
    logic [31:0] stall_addr;
    logic [31:0] exp_busy;
    logic [31:0] first_rd;
    logic [31:0] last_rd;
    logic [31:0] first_wr;
    logic [31:0] last_wr;
  } vec_t;

  task automatic start_xfer(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
    @(negedge clk_i); #1;
    src_addr_bi = s;
    dst_addr_bi = d;
    len_bi      = l;
    start_i     = 1'b1;
    @(negedge clk_i); #1;
    start_i     = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int busy_n, done_n, err_n, req_n, done_at, settle, n;
    busy_n = 0; done_n = 0; err_n = 0; req_n = 0; done_at = -1; settle = 0;
    clear_logs();
    stall_idx  = int'(v.stall_idx);
    stall_left = int'(v.stall_n);
    stall_addr = v.stall_addr;
    start_xfer(v.src, v.dst, v.len);
    for (int i = 0; i < 300; i++) begin
      if (settle >= 3) break;
      if (busy_o) busy_n++;
      if (ifc.bus_req_o) req_n++;
      if (err_o) err_n++;
      if (done_o) begin
        done_n++;
        if (done_at < 0) done_at = i;
        check({nm, "/busy_with_done"}, {31'd0, busy_o}, 32'd0);
      end
      if (done_n > 0 && !busy_o) settle++;
      @(negedge clk_i); #1;
    end
    check({nm, "/done_at"}, done_at, v.exp_busy);
    check({nm, "/busy_cycles"}, busy_n, v.exp_busy);
    check({nm, "/done_count"}, done_n, 32'd1);
    check({nm, "/err_count"}, err_n, 32'd0);
    check({nm, "/words_done"}, {16'd0, words_done_bo}, {16'd0, v.len});
    check({nm, "/n_reads"}, rd_log.size(), {16'd0, v.len});
    check({nm, "/n_writes"}, wr_addr_log.size(), {16'd0, v.len});
    n = rd_log.size();
    if (v.len == 16'd0) begin
      check({nm, "/req_cycles"}, req_n, 32'd0);
    end else if (n > 0 && wr_addr_log.size() == n) begin
      check({nm, "/first_rd"}, rd_log[0], v.first_rd);
      check({nm, "/last_rd"}, rd_log[n-1], v.last_rd);
      check({nm, "/first_wr"}, wr_addr_log[0], v.first_wr);
      check({nm, "/last_wr"}, wr_addr_log[n-1], v.last_wr);
      for (int k = 0; k < n; k++) begin
        check($sformatf("%s/rd_addr[%0d]", nm, k), rd_log[k], v.first_rd + 32'(4 * k));
        check($sformatf("%s/wr_addr[%0d]", nm, k), wr_addr_log[k], v.first_wr + 32'(4 * k));
        check($sformatf("%s/wr_data[%0d]", nm, k), wr_data_log[k], mdl(v.first_rd + 32'(4 * k)));
      end
    end
  endtask

  vec_t vecs[6];
  vec_t post;

  initial begin
    int acc_at, err_at, nerr, ndone, nreq, nbusy;
    bit found;

    //            src            dst            len    stl_i stl_n stl_addr       busy   first_rd       last_rd        first_wr       last_wr
    vecs[0] = '{32'h0000_0100, 32'h0000_0200, 16'd3, 32'd0, 32'd0, 32'h0,          32'd12, 32'h0000_0100, 32'h0000_0108, 32'h0000_0200, 32'h0000_0208};
    vecs[1] = '{32'h0000_0040, 32'h0000_0080, 16'd0, 32'd0, 32'd0, 32'h0,          32'd0,  32'h0,         32'h0,         32'h0,         32'h0};
    vecs[2] = '{32'hFFFF_FFFC, 32'h0000_1000, 16'd2, 32'd0, 32'd0, 32'h0,          32'd8,  32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_1000, 32'h0000_1004};
    vecs[3] = '{32'h0000_0103, 32'h0000_0302, 16'd1, 32'd0, 32'd0, 32'h0,          32'd4,  32'h0000_0100, 32'h0000_0100, 32'h0000_0300, 32'h0000_0300};
    vecs[4] = '{32'h0000_0010, 32'hFFFF_FFF8, 16'd4, 32'd0, 32'd0, 32'h0,          32'd16, 32'h0000_0010, 32'h0000_001C, 32'hFFFF_FFF8, 32'h0000_0004};
    vecs[5] = '{32'h0000_0500, 32'h0000_0600, 16'd3, 32'd1, 32'd5, 32'h0000_0504,  32'd17, 32'h0000_0500, 32'h0000_0508, 32'h0000_0600, 32'h0000_0608};
    post    = '{32'h0000_0040, 32'h0000_0044, 16'd1, 32'd0, 32'd0, 32'h0,          32'd4,  32'h0000_0040, 32'h0000_0040, 32'h0000_0044, 32'h0000_0044};

    arst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0;
    src_addr_bi = '0; dst_addr_bi = '0; len_bi = '0;
    repeat (2) @(negedge clk_i);
    check("rst/busy", {31'd0, busy_o}, 32'd0);
    check("rst/done_err", {30'd0, done_o, err_o}, 32'd0);
    check("rst/words_done", {16'd0, words_done_bo}, 32'd0);
    check("rst/req_we", {30'd0, ifc.bus_req_o, ifc.bus_we_o}, 32'd0);
    check("rst/addr", ifc.bus_addr_bo, 32'd0);
    check("rst/be", {28'd0, ifc.bus_be_bo}, 32'd0);
    check("rst/wdata", ifc.bus_wdata_bo, 32'd0);
    #1 arst_i = 1'b0;

    for (int v = 0; v < 6; v++) run_vec(vecs[v], $sformatf("vec%0d", v));
    check("be_after_xfer", {28'd0, ifc.bus_be_bo}, 32'h0000_000F);

    // Timeout: the read response never arrives.
    clear_logs();
    resp_on = 1'b0;
    acc_at = -100; err_at = -1; nerr = 0; ndone = 0;
    start_xfer(32'h0000_0700, 32'h0000_0800, 16'd2);
    for (int i = 0; i < 40; i++) begin
      if (ifc.bus_req_o && ifc.bus_ack_i && !ifc.bus_we_o) acc_at = i;
      if (err_o) begin
        nerr++;
        if (err_at < 0) err_at = i;
        check("tmo/busy_with_err", {31'd0, busy_o}, 32'd0);
        check("tmo/req_with_err", {31'd0, ifc.bus_req_o}, 32'd0);
      end
      if (done_o) ndone++;
      @(negedge clk_i); #1;
    end
    check("tmo/err_delay", err_at - acc_at, 32'd9);
    check("tmo/err_count", nerr, 32'd1);
    check("tmo/done_count", ndone, 32'd0);
    check("tmo/words_done", {16'd0, words_done_bo}, 32'd0);
    check("tmo/n_writes", wr_addr_log.size(), 32'd0);
    check("tmo/busy_end", {31'd0, busy_o}, 32'd0);
    resp_on = 1'b1;
    run_vec(post, "after_tmo");

    // Abort in RD_WAIT; the response then arrives while idle.
    clear_logs();
    found = 1'b0;
    start_xfer(32'h0000_0900, 32'h0000_0A00, 16'd2);
    for (int i = 0; i < 20; i++) begin
      if (ifc.bus_req_o && ifc.bus_ack_i && !ifc.bus_we_o) begin found = 1'b1; break; end
      @(negedge clk_i); #1;
    end
    check("abort/read_seen", {31'd0, found}, 32'd1);
    @(negedge clk_i); #1;
    check("abort/busy_in_wait", {31'd0, busy_o}, 32'd1);
    abort_i = 1'b1;
    @(negedge clk_i); #1;
    abort_i = 1'b0;
    ndone = 0; nerr = 0; nreq = 0; nbusy = 0;
    for (int i = 0; i < 5; i++) begin
      if (done_o) ndone++;
      if (err_o) nerr++;
      if (ifc.bus_req_o) nreq++;
      if (busy_o) nbusy++;
      @(negedge clk_i); #1;
    end
    check("abort/pulses", ndone + nerr, 32'd0);
    check("abort/req_cycles", nreq, 32'd0);
    check("abort/busy_cycles", nbusy, 32'd0);
    check("abort/wdata_kept", ifc.bus_wdata_bo, mdl(32'h0000_0040));
    check("abort/words_done", {16'd0, words_done_bo}, 32'd0);
    check("abort/n_writes", wr_addr_log.size(), 32'd0);

    // start_i while busy is ignored.
    clear_logs();
    ndone = 0;
    start_xfer(32'h0000_0B00, 32'h0000_0C00, 16'd1);
    @(negedge clk_i); #1;
    src_addr_bi = 32'h0000_0D00; len_bi = 16'd5; start_i = 1'b1;
    @(negedge clk_i); #1;
    start_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done_o) ndone++;
      @(negedge clk_i); #1;
    end
    check("busy_start/done_count", ndone, 32'd1);
    check("busy_start/words_done", {16'd0, words_done_bo}, 32'd1);
    check("busy_start/n_reads", rd_log.size(), 32'd1);
    check("busy_start/rd_addr", (rd_log.size() > 0) ? rd_log[0] : 32'hDEAD_DEAD, 32'h0000_0B00);

    // Asynchronous reset during a write request.
    clear_logs();
    found = 1'b0;
    start_xfer(32'h0000_0E00, 32'h0000_0F00, 16'd2);
    for (int i = 0; i < 20; i++) begin
      if (ifc.bus_req_o && ifc.bus_we_o) begin found = 1'b1; break; end
      @(negedge clk_i); #1;
    end
    check("arst/write_seen", {31'd0, found}, 32'd1);
    arst_i = 1'b1;
    #1;
    check("arst/req_now", {31'd0, ifc.bus_req_o}, 32'd0);
    check("arst/we_now", {31'd0, ifc.bus_we_o}, 32'd0);
    check("arst/addr", ifc.bus_addr_bo, 32'd0);
    check("arst/wdata", ifc.bus_wdata_bo, 32'd0);
    check("arst/be", {28'd0, ifc.bus_be_bo}, 32'd0);
    check("arst/words_done", {16'd0, words_done_bo}, 32'd0);
    check("arst/busy", {31'd0, busy_o}, 32'd0);
    @(negedge clk_i); #1;
    arst_i = 1'b0;
    ndone = 0; nerr = 0; nreq = 0;
    for (int i = 0; i < 5; i++) begin
      if (done_o) ndone++;
      if (err_o) nerr++;
      if (ifc.bus_req_o) nreq++;
      @(negedge clk_i); #1;
    end
    check("arst/pulses", ndone + nerr, 32'd0);
    check("arst/req_cycles", nreq, 32'd0);
    run_vec(vecs[0], "after_arst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
